// File: rtl/gp01_capture.sv
// gp01_capture: capture stage behind the gp01 accumulator.
// Accumulator samples ({overflow, data}) are pushed into a small first-word-fall-through FIFO.
// A push happens on a software request or automatically on overflow.
// Captured samples are presented to readout logic over valid/ready.
// A saturating counter tracks how many cycles had overflow set.
// Optional macro GP01_CAP_TIMESTAMP_EN adds an 8-bit free-running timestamp.
// When enabled, the timestamp is stored with each entry and the head's value appears on o_timestamp.
module gp01_capture #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_overflow,
    input  logic              i_capture,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W:0]   o_sample,
    output logic [CNT_W-1:0]  o_ovf_count,
    output logic              o_full,
    output logic              o_empty,
`ifdef GP01_CAP_TIMESTAMP_EN
    output logic [7:0]        o_timestamp,
`endif
    output logic              o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
`ifdef GP01_CAP_TIMESTAMP_EN
    localparam int TS_W = 8;
    localparam int EW   = DATA_W + 1 + TS_W;
`else
    localparam int EW   = DATA_W + 1;
`endif

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             full_q;
    logic             empty_q;
    logic             drop_q;
    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic [EW-1:0]    entry_in;
    logic [EW-1:0]    head;
    logic [CNT_W-1:0] ovf_cnt;

`ifdef GP01_CAP_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q;

    // Free-running timestamp; wraps naturally at 255 -> 0
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign entry_in = {ts_q, i_overflow, i_data};
`else
    assign entry_in = {i_overflow, i_data};
`endif

    // Handshake decode and next occupancy; a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        push_req   = i_capture | i_overflow;
        pop        = ~empty_q & i_ready;
        push_ok    = push_req & (~full_q | pop);
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, occupancy and registered status flags; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            full_q  <= (count_next == FULL_CNT);
            empty_q <= (count_next == '0);
            drop_q  <= push_req & full_q & ~pop;
        end
    end

    // Entry storage; a write during reset lands outside the readable window and is later overwritten
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Saturating overflow counter, independent of whether the push was accepted
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_cnt <= '0;
        end else if (i_overflow && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign o_valid     = ~empty_q;
    assign o_sample    = o_valid ? head[DATA_W:0] : '0;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_drop      = drop_q;
    assign o_ovf_count = ovf_cnt;
`ifdef GP01_CAP_TIMESTAMP_EN
    assign o_timestamp = o_valid ? head[EW-1 -: TS_W] : '0;
`endif

endmodule

// File: tb/tb_gp01_capture.sv
// Self-checking bench for gp01_capture.
// The expected response queue is filled when stimulus is issued.
// A negedge monitor pops and compares whenever the DUT hands over an entry.
module tb_gp01_capture;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [DATA_W-1:0] i_data;
    logic              i_overflow;
    logic              i_capture;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W:0]   o_sample;
    logic [CNT_W-1:0]  o_ovf_count;
    logic              o_full;
    logic              o_empty;
    logic              o_drop;
`ifdef GP01_CAP_TIMESTAMP_EN
    logic [7:0]        o_timestamp;
`endif

    int checkCount = 0;
    int failCount  = 0;

    // Expected entries: [14:7] timestamp, [6] overflow flag, [5:0] data
    logic [15:0] expQ[$];
    int          mCount;
    int          mOvf;
    int          mTs;
    logic        expDrop;

    gp01_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_overflow  (i_overflow),
        .i_capture   (i_capture),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_sample    (o_sample),
        .o_ovf_count (o_ovf_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
`ifdef GP01_CAP_TIMESTAMP_EN
        .o_timestamp (o_timestamp),
`endif
        .o_drop      (o_drop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Flag and head checks after each edge, against the bench's occupancy model
    task automatic checkState();
        checkOutput("empty", {31'd0, o_empty}, {31'd0, mCount == 0});
        checkOutput("full", {31'd0, o_full}, {31'd0, mCount == DEPTH});
        checkOutput("valid", {31'd0, o_valid}, {31'd0, mCount != 0});
        checkOutput("drop", {31'd0, o_drop}, {31'd0, expDrop});
        checkOutput("ovf_count", {24'd0, o_ovf_count}, mOvf);
        if (mCount != 0 && expQ.size() != 0) begin
            checkOutput("head_sample", {25'd0, o_sample}, {25'd0, expQ[0][6:0]});
        end
    endtask

    // Drive one cycle of inputs, update the model, then check right after the edge
    task automatic applyStimulus(input logic cap, input logic ovf, input logic [5:0] data, input logic ready);
        int   popNow;
        int   pushNow;
        int   accept;
        logic [7:0] tsNow;
        i_capture  = cap;
        i_overflow = ovf;
        i_data     = data;
        i_ready    = ready;
        tsNow      = mTs[7:0];
        popNow  = (mCount > 0 && ready) ? 1 : 0;
        pushNow = (cap || ovf) ? 1 : 0;
        accept  = (pushNow == 1 && (mCount < DEPTH || popNow == 1)) ? 1 : 0;
        if (accept == 1) begin
            expQ.push_back({1'b0, tsNow, ovf, data});
        end
        expDrop = (pushNow == 1 && accept == 0);
        mCount  = mCount + accept - popNow;
        if (ovf && mOvf < 255) begin
            mOvf++;
        end
        @(posedge clk);
        mTs = (mTs + 1) % 256;
        #1;
        checkState();
    endtask

    // Hold reset with pushes requested, check cleared state, release between edges
    task automatic doReset();
        i_rst      = 1'b1;
        i_capture  = 1'b1;
        i_overflow = 1'b1;
        i_data     = 6'd33;
        i_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_empty", {31'd0, o_empty}, 32'd1);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_full", {31'd0, o_full}, 32'd0);
        checkOutput("rst_drop", {31'd0, o_drop}, 32'd0);
        checkOutput("rst_ovf_count", {24'd0, o_ovf_count}, 32'd0);
        checkOutput("rst_sample", {25'd0, o_sample}, 32'd0);
        i_capture  = 1'b0;
        i_overflow = 1'b0;
        i_ready    = 1'b0;
        expQ.delete();
        mCount  = 0;
        mOvf    = 0;
        mTs     = 0;
        expDrop = 1'b0;
        i_rst   = 1'b0;
    endtask

    // Monitor: compare each entry the DUT hands over with the oldest expected entry
    always @(negedge clk) begin
        logic [15:0] e;
        if (!i_rst && o_valid && i_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("pop_unexpected", {25'd0, o_sample}, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("pop_sample", {25'd0, o_sample}, {25'd0, e[6:0]});
`ifdef GP01_CAP_TIMESTAMP_EN
                checkOutput("pop_timestamp", {24'd0, o_timestamp}, {24'd0, e[14:7]});
`endif
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst      = 1'b1;
        i_data     = '0;
        i_overflow = 1'b0;
        i_capture  = 1'b0;
        i_ready    = 1'b0;
        mCount     = 0;
        mOvf       = 0;
        mTs        = 0;
        expDrop    = 1'b0;
        #1;
        doReset();

        // First capture becomes visible one cycle after the request
        applyStimulus(1'b1, 1'b0, 6'd21, 1'b0);
        checkOutput("first_sample", {25'd0, o_sample}, 32'b0010101);
        checkOutput("first_valid", {31'd0, o_valid}, 32'd1);
`ifdef GP01_CAP_TIMESTAMP_EN
        checkOutput("first_timestamp", {24'd0, o_timestamp}, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);

        // Ordering: fill with ready low, then drain
        applyStimulus(1'b1, 1'b0, 6'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd12, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd40, 1'b0);
        checkOutput("order_full", {31'd0, o_full}, 32'd1);
        repeat (5) applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
        checkOutput("order_empty", {31'd0, o_empty}, 32'd1);

        // Drop when full without pop, accept when full with pop
        applyStimulus(1'b1, 1'b0, 6'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd12, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd40, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd9, 1'b0);
        checkOutput("drop_pulse", {31'd0, o_drop}, 32'd1);
        checkOutput("drop_head", {25'd0, o_sample}, 32'd3);
        applyStimulus(1'b1, 1'b0, 6'd9, 1'b1);
        checkOutput("nodrop", {31'd0, o_drop}, 32'd0);
        checkOutput("nodrop_full", {31'd0, o_full}, 32'd1);
        repeat (5) applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);

        // Overflow auto-capture
        applyStimulus(1'b0, 1'b1, 6'd63, 1'b0);
        checkOutput("ovf_sample", {25'd0, o_sample}, 32'b1111111);
        checkOutput("ovf_count_one", {24'd0, o_ovf_count}, 32'd1);
        repeat (2) applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);

        // Saturation with continuous push and pop; pointers wrap many times
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 6'(i), 1'b1);
        end
        checkOutput("ovf_saturated", {24'd0, o_ovf_count}, 32'd255);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);

        // Reset mid-stream: two stored entries vanish immediately
        applyStimulus(1'b1, 1'b0, 6'd17, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd18, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("midrst_empty", {31'd0, o_empty}, 32'd1);
        doReset();
        applyStimulus(1'b1, 1'b0, 6'd50, 1'b0);
        checkOutput("post_rst_sample", {25'd0, o_sample}, 32'd50);
`ifdef GP01_CAP_TIMESTAMP_EN
        checkOutput("post_rst_timestamp", {24'd0, o_timestamp}, 32'd0);
`endif
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
        checkOutput("final_queue", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
